// File: rtl/life_display_scan.sv
// Display back end for the life engine: captures the serial cell stream into a
// frame store and row-scans it onto the LED matrix with blanking and a blinking cursor.

module life_row_store #(
  parameter int X = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [X-1:0] wdata,
  output logic [X-1:0] q
);
  always_ff @(posedge clk) begin
    if (!reset)  q <= '0;
    else if (we) q <= wdata;
  end
endmodule

module life_display_scan #(
  parameter int X          = 8,
  parameter int Y          = 8,
  parameter int LOG2X      = 3,
  parameter int LOG2Y      = 3,
  parameter int DWELL      = 16,
  parameter int BLANK      = 2,
  parameter int BLINK_LOG2 = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   nxt_bit,
  input  logic                   data_in,
  input  logic [LOG2X+LOG2Y-1:0] cnt,
  input  logic [LOG2X-1:0]       cursor_x,
  input  logic [LOG2Y-1:0]       cursor_y,
  input  logic                   cursor_en,
  output logic [X-1:0]           col,
  output logic [Y-1:0]           row_sel,
  output logic                   row_wr,
  output logic                   frame_tick
);
  typedef enum logic {S_BLANK, S_DRIVE} state_t;

  state_t                  state;
  logic [7:0]              phase;
  logic [LOG2Y-1:0]        row;
  logic [BLINK_LOG2:0]     blink_cnt;
  logic [X-2:0]            line_buf;
  logic [Y-1:0][X-1:0]     frame_q;
  logic [Y-1:0]            row_we;
  logic [LOG2X-1:0]        cx;
  logic [LOG2Y-1:0]        cy;
  logic                    in_range, last_x, line_done;
  logic [X-1:0]            line_word;
  logic [X-1:0]            disp;

  assign cx        = cnt[LOG2X-1:0];
  assign cy        = cnt[LOG2X+LOG2Y-1:LOG2X];
  assign in_range  = (int'(cx) < X) && (int'(cy) < Y);
  assign last_x    = (int'(cx) == X-1);
  assign line_done = nxt_bit && in_range && last_x;
  assign line_word = {data_in, line_buf[X-2:0]};

  // The last cell of a line is never stored here; it goes straight into the frame.
  always_ff @(posedge clk) begin
    if (!reset)                               line_buf     <= '0;
    else if (nxt_bit && in_range && !last_x)  line_buf[cx] <= data_in;
  end

  for (genvar i = 0; i < Y; i++) begin : g_row
    assign row_we[i] = line_done && (int'(cy) == i);
    life_row_store #(.X(X)) u_row (
      .clk   (clk),
      .reset (reset),
      .we    (row_we[i]),
      .wdata (line_word),
      .q     (frame_q[i])
    );
  end

  // A line landing on the row being driven is forwarded so it shows next cycle.
  always_comb begin
    disp = frame_q[row];
    if (line_done && (cy == row)) disp = line_word;
    if (cursor_en && (cursor_y == row) && blink_cnt[BLINK_LOG2])
      disp = disp ^ (X'(1) << cursor_x);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= S_BLANK;
      phase      <= '0;
      row        <= '0;
      blink_cnt  <= '0;
      col        <= '0;
      row_sel    <= '0;
      row_wr     <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      row_wr     <= line_done;
      frame_tick <= 1'b0;
      col        <= '0;
      row_sel    <= '0;
      case (state)
        S_BLANK: begin
          if (phase == 8'(BLANK-1)) begin
            state <= S_DRIVE;
            phase <= '0;
          end else begin
            phase <= phase + 8'd1;
          end
        end
        S_DRIVE: begin
          row_sel <= Y'(1) << row;
          col     <= disp;
          if (phase == 8'(DWELL-1)) begin
            state <= S_BLANK;
            phase <= '0;
            if (row == LOG2Y'(Y-1)) begin
              row        <= '0;
              frame_tick <= 1'b1;
              blink_cnt  <= blink_cnt + 1'b1;
            end else begin
              row <= row + 1'b1;
            end
          end else begin
            phase <= phase + 8'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_life_display_scan.sv
// Bench for life_display_scan: time-indexed scan model checked every cycle,
// plus directed literal checks for reset, streaming, timing, commit bypass and cursor.

module tb_life_display_scan;
  localparam int X = 8, Y = 8, DWELL = 16, BLANK = 2;
  localparam int RP = BLANK + DWELL;
  localparam int FP = Y * RP;

  logic       clk = 1'b0, reset = 1'b0, nxt_bit = 1'b0, data_in = 1'b0, cursor_en = 1'b0;
  logic [5:0] cnt = '0;
  logic [2:0] cursor_x = '0, cursor_y = '0;
  logic [7:0] col, row_sel;
  logic       row_wr, frame_tick;

  life_display_scan dut (
    .clk(clk), .reset(reset), .nxt_bit(nxt_bit), .data_in(data_in), .cnt(cnt),
    .cursor_x(cursor_x), .cursor_y(cursor_y), .cursor_en(cursor_en),
    .col(col), .row_sel(row_sel), .row_wr(row_wr), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int n_assert = 0, n_fail = 0;
  int wr_cnt = 0, cyc_n = 0;

  // Model: m_t counts cycles since reset release; outputs follow from it arithmetically.
  logic [7:0] m_frame [Y];
  logic [7:0] m_line;
  int         m_t = 0, m_p, m_r;
  logic [7:0] m_cur;
  logic [7:0] e_col = '0, e_row_sel = '0;
  logic       e_wr = 1'b0, e_tick = 1'b0;

  always @(posedge clk) begin
    if (!reset) begin
      m_t = 0;
      m_line = '0;
      for (int i = 0; i < Y; i++) m_frame[i] = '0;
      e_col = '0; e_row_sel = '0; e_wr = 1'b0; e_tick = 1'b0;
    end else begin
      e_wr = 1'b0;
      if (nxt_bit) begin
        m_line[cnt[2:0]] = data_in;
        if (cnt[2:0] == 3'd7) begin
          m_frame[cnt[5:3]] = m_line;
          e_wr = 1'b1;
        end
      end
      m_p = m_t % FP;
      m_r = m_p / RP;
      if ((m_p % RP) >= BLANK) begin
        m_cur = m_frame[m_r];
        if (cursor_en && int'(cursor_y) == m_r && ((m_t / FP) % 16) >= 8)
          m_cur[cursor_x] = ~m_cur[cursor_x];
        e_col = m_cur;
        e_row_sel = 8'(1 << m_r);
      end else begin
        e_col = '0;
        e_row_sel = '0;
      end
      e_tick = (m_p == FP - 1);
      m_t++;
    end
  end

  always @(negedge clk) begin
    cyc_n++;
    if (row_wr === 1'b1) wr_cnt++;
    n_assert++;
    if ({col, row_sel, row_wr, frame_tick} !== {e_col, e_row_sel, e_wr, e_tick}) begin
      n_fail++;
      $display("FAIL scan t=%0d: col=%h row_sel=%h row_wr=%b frame_tick=%b, expected %h %h %b %b",
               m_t, col, row_sel, row_wr, frame_tick, e_col, e_row_sel, e_wr, e_tick);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_bit(input int idx, input logic v);
    nxt_bit = 1'b1;
    cnt     = 6'(idx);
    data_in = v;
    tick();
    nxt_bit = 1'b0;
    data_in = 1'b0;
  endtask

  task automatic wait_row(input logic [7:0] rs);
    int k;
    k = 0;
    while (row_sel !== rs && k < 400) begin k++; tick(); end
    if (k >= 400) begin
      n_assert++; n_fail++;
      $display("FAIL wait_row: row_sel %h never seen", rs);
    end
  endtask

  task automatic wait_tick();
    int k;
    k = 0;
    tick();
    while (frame_tick !== 1'b1 && k < 400) begin k++; tick(); end
    if (k >= 400) begin
      n_assert++; n_fail++;
      $display("FAIL wait_tick: frame_tick never seen");
    end
  endtask

  task automatic release_and_measure(input string name);
    int k;
    reset = 1'b1;
    k = 0;
    tick();
    while (row_sel === 8'h00 && k < 50) begin k++; tick(); end
    chk(name, k, BLANK);
    chk({name, "_rowsel"}, int'(row_sel), 8'h01);
  endtask

  initial begin
    int w0, c0, c1, c2, k, g;
    logic [7:0] pat, col_before, col_or;

    // T1: reset then first row after BLANK cycles
    reset = 1'b0;
    repeat (3) tick();
    chk("reset_col", int'(col), 0);
    chk("reset_row_sel", int'(row_sel), 0);
    chk("reset_pulses", int'({row_wr, frame_tick}), 0);
    release_and_measure("t1_first_row");

    // T2: full 64-cell frame with cells 9 and 63 alive
    w0 = wr_cnt;
    for (int i = 0; i < 64; i++) drive_bit(i, (i == 9 || i == 63));
    tick();
    chk("t2_row_wr_count", wr_cnt - w0, 8);
    wait_tick();
    wait_row(8'h02); chk("t2_row1_col", int'(col), 8'h02);
    wait_row(8'h80); chk("t2_row7_col", int'(col), 8'h80);
    wait_row(8'h04); chk("t2_row2_col", int'(col), 8'h00);

    // T3: frame period and row hold/gap lengths
    wait_tick(); c0 = cyc_n;
    wait_tick(); c1 = cyc_n;
    wait_tick(); c2 = cyc_n;
    chk("t3_period_a", c1 - c0, FP);
    chk("t3_period_b", c2 - c1, FP);
    wait_row(8'h10);
    k = 0;
    while (row_sel === 8'h10 && k < 50) begin k++; tick(); end
    chk("t3_hold", k, DWELL);
    g = 0;
    while (row_sel === 8'h00 && g < 50) begin g++; tick(); end
    chk("t3_gap", g, BLANK);
    chk("t3_next_row", int'(row_sel), 8'h20);

    // T5: commit row 2 while it is being driven
    k = 0;
    while ((m_t % FP) != 40 && k < 400) begin k++; tick(); end
    pat = 8'hA5;
    col_before = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      drive_bit(16 + i, pat[i]);
      if (i == 6) col_before = col;
    end
    chk("t5_before_commit", int'(col_before), 8'h00);
    chk("t5_after_commit", int'(col), 8'hA5);
    chk("t5_row_sel", int'(row_sel), 8'h04);

    // T6: reset after a partial line
    w0 = wr_cnt;
    for (int i = 0; i < 5; i++) drive_bit(24 + i, 1'b1);
    reset = 1'b0;
    tick(); tick();
    chk("t6_no_row_wr", wr_cnt - w0, 0);
    release_and_measure("t6_first_row");
    col_or = '0;
    for (int i = 0; i < FP; i++) begin col_or |= col; tick(); end
    chk("t6_frame_clear", int'(col_or), 0);

    // T4: blinking cursor on an empty frame
    cursor_en = 1'b1; cursor_x = 3'd3; cursor_y = 3'd5;
    reset = 1'b0;
    tick(); tick();
    reset = 1'b1;
    for (int f = 0; f < 17; f++) begin
      wait_row(8'h20);
      chk($sformatf("t4_cursor_f%0d", f), int'(col), ((f / 8) % 2) ? 8'h08 : 8'h00);
      k = 0;
      while (row_sel === 8'h20 && k < 50) begin k++; tick(); end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $fatal(1);
  end
endmodule
